sd_read_ctrl: RTL and testbench
===============================

Name: sd_read_ctrl

Overview:
Sequencer for multi-block SD card reads over the 4-bit data reader. The host requests N blocks from a start address. For each block the controller arms the data reader, issues a single-block read command (CMD17) through the command engine, and waits for the reader to finish. It then checks the reader's status byte, retries failed blocks and advances the block address until all N blocks are delivered or an unrecoverable error occurs.

Parameters:
BLK_LEN, 512, bytes per block; driven on o_buf_len.
MAX_RETRY, 3, extra attempts allowed per block after a CRC or data-timeout failure (0 to 7).
ARM_TMO, 64, cycles allowed for i_sd_run to rise after the arm pulse.
CMD_IDX, 17, command index for a single-block read.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  start pulse; accepted only in IDLE
i_blk_addr  in  32  first block address, latched on accept
i_blk_cnt  in  16  number of blocks, latched on accept; 0 means no-op
i_byte_addr  in  1  1 = card uses byte addressing (address step 512), 0 = block addressing (step 1); latched on accept
i_abort  in  1  abort the current request
o_cmd_start  out  1  one-cycle pulse to the command engine
o_cmd_idx  out  6  command index (CMD_IDX)
o_cmd_arg  out  32  command argument (current address)
i_cmd_done  in  1  one-cycle pulse: response received
i_cmd_err  in  1  qualified by i_cmd_done: response error
o_start_reading  out  1  reader arm; the reader triggers on its rising edge
o_buf_len  out  10  BLK_LEN[9:0], constant
i_sd_run  in  1  reader busy
i_sd_result  in  8  reader status: bit0 = start-bit timeout, bits4:1 = per-line CRC mismatch
o_busy  out  1  high outside IDLE
o_done  out  1  one-cycle pulse when the request completes (OK or error)
o_err  out  1  sticky error flag; cleared on the next accepted i_req
o_err_code  out  3  0 none, 1 cmd error, 2 CRC retries exhausted, 3 data timeout retries exhausted, 4 arm timeout, 5 aborted
o_blk_done  out  16  number of blocks completed successfully

Behaviour:
- Reset values: all outputs 0, except o_buf_len = BLK_LEN and o_cmd_idx = CMD_IDX (both constants); state IDLE.
- Latched registers:
  - addr (32-bit), remaining (16-bit), retry count (3-bit), timer (16-bit).
- State machine:
  - IDLE: on i_req, latch inputs, clear o_err, o_err_code and o_blk_done. If i_blk_cnt == 0, pulse o_done and stay in IDLE. Otherwise go to ARM.
  - ARM: drive o_start_reading = 1 for exactly one cycle, clear the timer, go to ARM_WAIT.
  - ARM_WAIT: o_start_reading = 0. When i_sd_run = 1, go to CMD. If the timer reaches ARM_TMO, error code 4, go to FIN.
  - CMD: drive o_cmd_start for one cycle with o_cmd_arg = addr, go to CMD_WAIT.
  - CMD_WAIT: on i_cmd_done with i_cmd_err = 1, record code 1 and go to DRAIN. On i_cmd_done with i_cmd_err = 0, go to DATA.
  - DATA: wait for i_sd_run to fall. In the first cycle i_sd_run is low, register i_sd_result (it is valid only in that cycle) and go to CHECK.
  - CHECK:
    - Result[4:0] == 0: addr += (i_byte_addr ? 512 : 1) with 32-bit wrap; o_blk_done += 1; remaining -= 1; retry = 0. If remaining reaches 0, go to FIN (OK); otherwise go to ARM.
    - Any failure bit set and retry < MAX_RETRY: retry += 1, go to ARM with the same addr.
    - Failures remaining with retries exhausted: code 3 if bit0 is set, else code 2; go to FIN. Bit0 takes priority over CRC bits.
  - DRAIN: wait until i_sd_run = 0 (the reader times out on its own), then go to FIN.
  - FIN: pulse o_done, set o_err if the code is nonzero, go to IDLE.
- o_start_reading is low for at least 1 cycle between arms; a retry always passes through ARM, so the reader sees a fresh rising edge.
- i_abort is honoured in any non-IDLE state:
  - If i_sd_run = 1, go to DRAIN with code 5.
  - Otherwise go to FIN with code 5.
  - If i_abort coincides with i_cmd_done, abort wins.
- i_req while busy is ignored.
- Reset mid-operation returns to IDLE immediately and forces o_start_reading low. The reader is reset by the same rst_n.
- i_cmd_done outside CMD_WAIT is ignored.

Decomposition:
- Package sd_pkg holds:
  - the state enum;
  - the error-code constants (ERR_NONE, ERR_CMD, ERR_CRC, ERR_DTMO, ERR_ARM, ERR_ABORT);
  - the result bit positions (RES_DTMO = 0, RES_CRC = 4:1);
  - CMD17_IDX.
- One natural sub-module, sd_blk_retry: holds the retry counter and the pass/retry/fail decision from a registered result. The state machine and address logic stay in the top module.

Test Plan:
- Req addr=0x100, cnt=3, block addressing; reader model returns result 0x00 each time -> 3 arm pulses; o_cmd_arg = 0x100, 0x101, 0x102; o_blk_done = 3; o_done pulse; o_err = 0.
- Byte addressing, addr=0x0000_0000, cnt=2 -> o_cmd_arg = 0x0 then 0x200.
- First attempt returns 0x04 (CRC error on line 1), second attempt returns 0x00 -> two CMD17s with the same argument; o_blk_done = 1; o_err = 0.
- Every attempt returns 0x01, MAX_RETRY = 3 -> exactly 4 arm pulses for that block; o_err = 1; o_err_code = 3; o_blk_done = 0.
- i_cmd_err on the first block -> controller waits for i_sd_run to fall, then o_done; o_err_code = 1; no further o_cmd_start.
- i_sd_run never rises -> o_done ARM_TMO+2 cycles after the arm pulse, o_err_code = 4. Separately, i_abort during DATA -> o_err_code = 5 only after i_sd_run falls.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared types and constants for the SD multi-block read
//                sequencer: FSM states, error codes, reader status bit map.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARM      = 4'd1,
    ST_ARM_WAIT = 4'd2,
    ST_CMD      = 4'd3,
    ST_CMD_WAIT = 4'd4,
    ST_DATA     = 4'd5,
    ST_CHECK    = 4'd6,
    ST_DRAIN    = 4'd7,
    ST_FIN      = 4'd8
  } sd_state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CMD   = 3'd1;
  localparam logic [2:0] ERR_CRC   = 3'd2;
  localparam logic [2:0] ERR_DTMO  = 3'd3;
  localparam logic [2:0] ERR_ARM   = 3'd4;
  localparam logic [2:0] ERR_ABORT = 3'd5;

  // Reader status byte: bit0 start-bit timeout, bits 4:1 per-line CRC error
  localparam int RES_DTMO    = 0;
  localparam int RES_CRC_LSB = 1;
  localparam int RES_CRC_MSB = 4;

  localparam logic [5:0] CMD17_IDX = 6'd17;

  // A data timeout outranks CRC errors when both are reported
  function automatic logic [2:0] fail_code(input logic [4:0] res);
    return res[RES_DTMO] ? ERR_DTMO : ERR_CRC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_blk_retry.sv
`default_nettype none
// ============================================================================
//  Module      : sd_blk_retry
//  Description : Holds the captured reader status and the per-block retry
//                counter; decides pass / retry / fail for the current block.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_blk_retry
  import sd_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [4:0] i_result,
  input  logic       i_commit,
  output logic       o_pass,
  output logic       o_retry,
  output logic [2:0] o_fail_code
);

  logic [4:0] r_result;
  logic [2:0] r_retry;

  // Capture the status byte in the single cycle the reader presents it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 5'd0;
    end else if (i_load) begin
      r_result <= i_result;
    end
  end

  // Retry count restarts for every new block and every new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= 3'd0;
    end else if (i_clr) begin
      r_retry <= 3'd0;
    end else if (i_commit) begin
      if (o_pass) begin
        r_retry <= 3'd0;
      end else if (o_retry) begin
        r_retry <= r_retry + 3'd1;
      end
    end
  end

  // Decision from the registered status and attempts already spent
  always_comb begin
    o_pass      = (r_result == 5'd0);
    o_retry     = !o_pass && (r_retry < 3'(MAX_RETRY));
    o_fail_code = fail_code(r_result);
  end

endmodule
`default_nettype wire

// File: rtl/sd_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sd_read_ctrl
//  Description : Multi-block SD read sequencer. Arms the 4-bit data reader,
//                issues CMD17 per block, retries failed blocks and advances
//                the block address until the request completes or errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_read_ctrl
  import sd_pkg::*;
#(
  parameter int         BLK_LEN   = 512,
  parameter int         MAX_RETRY = 3,
  parameter int         ARM_TMO   = 64,
  parameter logic [5:0] CMD_IDX   = CMD17_IDX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_blk_addr,
  input  logic [15:0] i_blk_cnt,
  input  logic        i_byte_addr,
  input  logic        i_abort,
  output logic        o_cmd_start,
  output logic [5:0]  o_cmd_idx,
  output logic [31:0] o_cmd_arg,
  input  logic        i_cmd_done,
  input  logic        i_cmd_err,
  output logic        o_start_reading,
  output logic [9:0]  o_buf_len,
  input  logic        i_sd_run,
  input  logic [7:0]  i_sd_result,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [2:0]  o_err_code,
  output logic [15:0] o_blk_done
);

  sd_state_t   r_state, w_next;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [15:0] r_timer;
  logic [15:0] r_blk_done;
  logic [2:0]  r_code;
  logic        r_err;
  logic        r_byte_addr;
  logic        r_nop_done;

  logic        w_accept, w_load, w_commit, w_blk_ok, w_set_code;
  logic [2:0]  w_code_val;
  logic        w_pass, w_retry;
  logic [2:0]  w_fail_code;
  logic        w_unused;

  // Status bits 7:5 carry nothing this controller acts on
  assign w_unused = ^i_sd_result[7:5];

  sd_blk_retry #(
    .MAX_RETRY (MAX_RETRY)
  ) u_retry (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_accept),
    .i_load      (w_load),
    .i_result    (i_sd_result[RES_CRC_MSB:RES_DTMO]),
    .i_commit    (w_commit),
    .o_pass      (w_pass),
    .o_retry     (w_retry),
    .o_fail_code (w_fail_code)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-cycle control strobes; abort overrides everything
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_commit   = 1'b0;
    w_blk_ok   = 1'b0;
    w_set_code = 1'b0;
    w_code_val = ERR_NONE;
    if (i_abort && (r_state != ST_IDLE) && (r_state != ST_FIN)) begin
      w_set_code = 1'b1;
      w_code_val = ERR_ABORT;
      w_next     = i_sd_run ? ST_DRAIN : ST_FIN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            w_accept = 1'b1;
            if (i_blk_cnt != 16'd0) w_next = ST_ARM;
          end
        end
        ST_ARM:      w_next = ST_ARM_WAIT;
        ST_ARM_WAIT: begin
          if (i_sd_run) begin
            w_next = ST_CMD;
          end else if (r_timer == 16'(ARM_TMO)) begin
            w_set_code = 1'b1;
            w_code_val = ERR_ARM;
            w_next     = ST_FIN;
          end
        end
        ST_CMD:      w_next = ST_CMD_WAIT;
        ST_CMD_WAIT: begin
          if (i_cmd_done) begin
            if (i_cmd_err) begin
              w_set_code = 1'b1;
              w_code_val = ERR_CMD;
              w_next     = ST_DRAIN;
            end else begin
              w_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!i_sd_run) begin
            w_load = 1'b1;
            w_next = ST_CHECK;
          end
        end
        ST_CHECK: begin
          w_commit = 1'b1;
          if (w_pass) begin
            w_blk_ok = 1'b1;
            w_next   = (r_remaining == 16'd1) ? ST_FIN : ST_ARM;
          end else if (w_retry) begin
            w_next = ST_ARM;
          end else begin
            w_set_code = 1'b1;
            w_code_val = w_fail_code;
            w_next     = ST_FIN;
          end
        end
        ST_DRAIN: begin
          if (!i_sd_run) w_next = ST_FIN;
        end
        ST_FIN:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Request latch, arm timer, address/progress counters and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 32'd0;
      r_remaining <= 16'd0;
      r_timer     <= 16'd0;
      r_blk_done  <= 16'd0;
      r_code      <= ERR_NONE;
      r_err       <= 1'b0;
      r_byte_addr <= 1'b0;
      r_nop_done  <= 1'b0;
    end else begin
      r_nop_done <= w_accept && (i_blk_cnt == 16'd0);
      if (w_accept) begin
        r_addr      <= i_blk_addr;
        r_remaining <= i_blk_cnt;
        r_byte_addr <= i_byte_addr;
        r_code      <= ERR_NONE;
        r_err       <= 1'b0;
        r_blk_done  <= 16'd0;
      end
      if (r_state == ST_ARM) begin
        r_timer <= 16'd0;
      end else if (r_state == ST_ARM_WAIT) begin
        r_timer <= r_timer + 16'd1;
      end
      if (w_set_code) r_code <= w_code_val;
      if (w_blk_ok) begin
        r_addr      <= r_addr + (r_byte_addr ? 32'd512 : 32'd1);
        r_blk_done  <= r_blk_done + 16'd1;
        r_remaining <= r_remaining - 16'd1;
      end
      if ((r_state == ST_FIN) && (r_code != ERR_NONE)) r_err <= 1'b1;
    end
  end

  assign o_start_reading = (r_state == ST_ARM);
  assign o_cmd_start     = (r_state == ST_CMD);
  assign o_cmd_idx       = CMD_IDX;
  assign o_cmd_arg       = r_addr;
  assign o_buf_len       = 10'(BLK_LEN);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_FIN) || r_nop_done;
  assign o_err           = r_err;
  assign o_err_code      = r_code;
  assign o_blk_done      = r_blk_done;

endmodule
`default_nettype wire

// File: tb/tb_sd_read_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sd_read_ctrl
//  Description : Self-checking bench for sd_read_ctrl with reactive reader
//                and command-engine models and a block/attempt-level
//                reference model of the request outcome.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_read_ctrl;

  localparam int MAXR = 3;
  localparam int ATMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_blk_addr = 32'd0;
  logic [15:0] i_blk_cnt = 16'd0;
  logic        i_byte_addr = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_cmd_start;
  logic [5:0]  o_cmd_idx;
  logic [31:0] o_cmd_arg;
  logic        i_cmd_done;
  logic        i_cmd_err;
  logic        o_start_reading;
  logic [9:0]  o_buf_len;
  logic        i_sd_run;
  logic [7:0]  i_sd_result;
  logic        o_busy, o_done, o_err;
  logic [2:0]  o_err_code;
  logic [15:0] o_blk_done;

  sd_read_ctrl #(.BLK_LEN(512), .MAX_RETRY(MAXR), .ARM_TMO(ATMO), .CMD_IDX(6'd17)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_blk_addr(i_blk_addr),
    .i_blk_cnt(i_blk_cnt), .i_byte_addr(i_byte_addr), .i_abort(i_abort),
    .o_cmd_start(o_cmd_start), .o_cmd_idx(o_cmd_idx), .o_cmd_arg(o_cmd_arg),
    .i_cmd_done(i_cmd_done), .i_cmd_err(i_cmd_err), .o_start_reading(o_start_reading),
    .o_buf_len(o_buf_len), .i_sd_run(i_sd_run), .i_sd_result(i_sd_result),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
    .o_blk_done(o_blk_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Environment controls
  bit         no_run = 1'b0;
  bit         cmd_err_mode = 1'b0;
  int         hold_extra = 0;
  logic [7:0] rdr_q[$];
  logic [7:0] plan[$];

  // Monitor results
  int          cyc = 0, n_arm = 0, n_done = 0, dbl_arm = 0;
  int          arm_cyc = 0, done_cyc = 0, fall_cyc = 0;
  logic [31:0] got_args[$];
  bit          prev_sr = 1'b0, prev_run = 1'b0;

  // Expected outcome of the current request
  logic [31:0] exp_args[$];
  int          exp_arms, exp_blks, exp_code;
  int          a0, g0, d0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Command engine: answers each CMD17 after 1..4 cycles
  initial begin
    i_cmd_done = 1'b0;
    i_cmd_err  = 1'b0;
    forever begin
      @(negedge clk);
      i_cmd_done = 1'b0;
      i_cmd_err  = 1'($urandom);
      if (o_cmd_start) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        i_cmd_done = 1'b1;
        i_cmd_err  = cmd_err_mode;
      end
    end
  end

  // Data reader: rises after arm, falls some cycles after the response,
  // status valid only in the first low cycle
  initial begin
    i_sd_run    = 1'b0;
    i_sd_result = 8'd0;
    forever begin
      @(negedge clk);
      if (o_start_reading && !no_run) begin
        bit err;
        int w;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        i_sd_run = 1'b1;
        w = 0;
        do begin
          @(posedge clk);
          w++;
        end while (!i_cmd_done && w < 300);
        err = i_cmd_err;
        @(negedge clk);
        repeat ($urandom_range(2, 6) + hold_extra) @(negedge clk);
        i_sd_run = 1'b0;
        if (err || rdr_q.size() == 0) i_sd_result = 8'h01;
        else                          i_sd_result = rdr_q.pop_front();
        @(negedge clk);
        i_sd_result = 8'($urandom);
      end
    end
  end

  // Observe DUT just after the falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (o_start_reading) begin
        n_arm++;
        arm_cyc = cyc;
        if (prev_sr) dbl_arm++;
      end
      prev_sr = o_start_reading;
      if (o_cmd_start) got_args.push_back(o_cmd_arg);
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (prev_run && !i_sd_run) fall_cyc = cyc;
      prev_run = i_sd_run;
    end
  end

  // Block/attempt-level model of one request
  task automatic ref_run(input logic [31:0] addr, input int cnt, input bit bmode, input bit cerr);
    int k;
    logic [31:0] a;
    logic [7:0] r;
    exp_args.delete();
    exp_arms = 0; exp_blks = 0; exp_code = 0; k = 0; a = addr;
    for (int b = 0; b < cnt && exp_code == 0; b++) begin
      for (int t = 0; t <= MAXR; t++) begin
        exp_arms++;
        exp_args.push_back(a);
        if (cerr) begin exp_code = 1; break; end
        r = plan[k];
        k++;
        if (r[4:0] == 5'd0) begin exp_blks++; break; end
        if (t == MAXR) exp_code = r[0] ? 3 : 2;
      end
      a = a + (bmode ? 32'd512 : 32'd1);
    end
  endtask

  // mode: 0 plain, 1 extra i_req while busy, 2 abort during data phase
  task automatic do_req(input logic [31:0] addr, input logic [15:0] cnt, input bit bmode, input int mode);
    int t;
    d0 = n_done; a0 = n_arm; g0 = got_args.size();
    rdr_q = plan;
    @(negedge clk);
    i_blk_addr = addr; i_blk_cnt = cnt; i_byte_addr = bmode; i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    i_blk_addr = $urandom; i_blk_cnt = 16'($urandom); i_byte_addr = 1'($urandom);
    if (mode == 1) begin
      repeat (4) @(negedge clk);
      i_req = 1'b1;
      @(negedge clk);
      i_req = 1'b0;
    end else if (mode == 2) begin
      t = 0;
      do begin @(posedge clk); t++; end while (!i_cmd_done && t < 500);
      @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
    end
    t = 0;
    while (n_done == d0 && t < 20000) begin
      @(negedge clk);
      #2;
      t++;
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic check_req(input string tag);
    chk({tag, ".done_pulses"}, n_done - d0, 1);
    chk({tag, ".arms"}, n_arm - a0, exp_arms);
    chk({tag, ".ncmd"}, got_args.size() - g0, exp_args.size());
    for (int i = 0; i < exp_args.size(); i++)
      chk({tag, ".arg"}, (g0 + i < got_args.size()) ? got_args[g0 + i] : 32'hDEAD_BEEF, exp_args[i]);
    chk({tag, ".blk_done"}, o_blk_done, exp_blks);
    chk({tag, ".err_code"}, o_err_code, exp_code);
    chk({tag, ".err"}, o_err, (exp_code != 0));
    chk({tag, ".busy"}, o_busy, 0);
    chk({tag, ".arm_gap"}, dbl_arm, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int cnt;
    bit bm;
    logic [7:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.buf_len", o_buf_len, 512);
    chk("rst.cmd_idx", o_cmd_idx, 17);
    chk("rst.busy", o_busy, 0);
    chk("rst.done", o_done, 0);
    chk("rst.start_reading", o_start_reading, 0);
    chk("rst.cmd_start", o_cmd_start, 0);
    chk("rst.cmd_arg", o_cmd_arg, 0);
    chk("rst.err", {o_err, o_err_code}, 0);
    chk("rst.blk_done", o_blk_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three blocks, block addressing, all clean
    plan = '{8'h00, 8'h00, 8'h00};
    ref_run(32'h100, 3, 1'b0, 1'b0);
    do_req(32'h100, 16'd3, 1'b0, 0);
    check_req("blk3");

    // Byte addressing from zero
    plan = '{8'h00, 8'h00};
    ref_run(32'h0, 2, 1'b1, 1'b0);
    do_req(32'h0, 16'd2, 1'b1, 0);
    check_req("byte2");

    // CRC error on line 1 then success
    plan = '{8'h04, 8'h00};
    ref_run(32'h55, 1, 1'b0, 1'b0);
    do_req(32'h55, 16'd1, 1'b0, 0);
    check_req("crc_retry");

    // Data timeout on every attempt: retries exhausted
    plan = '{8'h01, 8'h01, 8'h01, 8'h01};
    ref_run(32'h77, 1, 1'b0, 1'b0);
    do_req(32'h77, 16'd1, 1'b0, 0);
    check_req("dtmo_exh");

    // Timeout together with CRC bits on the final attempt: timeout wins
    plan = '{8'h03, 8'h12, 8'h06, 8'h1F};
    ref_run(32'h88, 1, 1'b0, 1'b0);
    do_req(32'h88, 16'd1, 1'b0, 0);
    check_req("prio");

    // Command error: drain reader, no further commands
    plan.delete();
    cmd_err_mode = 1'b1;
    ref_run(32'h200, 2, 1'b0, 1'b1);
    do_req(32'h200, 16'd2, 1'b0, 0);
    cmd_err_mode = 1'b0;
    check_req("cmd_err");
    chk("cmd_err.done_after_fall", done_cyc - fall_cyc, 1);

    // Reader never starts: arm timeout
    no_run = 1'b1;
    exp_args.delete(); exp_arms = 1; exp_blks = 0; exp_code = 4;
    do_req(32'h300, 16'd1, 1'b0, 0);
    no_run = 1'b0;
    check_req("arm_tmo");
    chk("arm_tmo.latency", done_cyc - arm_cyc, ATMO + 2);

    // Address wrap in byte mode; also clears the previous error
    plan = '{8'h00, 8'h00};
    ref_run(32'hFFFF_FE00, 2, 1'b1, 1'b0);
    do_req(32'hFFFF_FE00, 16'd2, 1'b1, 0);
    check_req("wrap");

    // Abort during data phase: completes only after the reader goes idle
    plan = '{8'h00};
    hold_extra = 20;
    exp_args.delete(); exp_args.push_back(32'h400);
    exp_arms = 1; exp_blks = 0; exp_code = 5;
    do_req(32'h400, 16'd1, 1'b0, 2);
    hold_extra = 0;
    check_req("abort");
    chk("abort.done_after_fall", done_cyc - fall_cyc, 1);

    // Zero-length request
    plan.delete();
    ref_run(32'h500, 0, 1'b0, 1'b0);
    do_req(32'h500, 16'd0, 1'b0, 0);
    check_req("nop");

    // Randomized requests against the model; first one sees a stray i_req
    for (int n = 0; n < 8; n++) begin
      addr = $urandom;
      cnt  = $urandom_range(1, 4);
      bm   = 1'($urandom);
      plan.delete();
      for (int j = 0; j < cnt * (MAXR + 1); j++) begin
        v = 8'($urandom);
        if ($urandom_range(0, 9) < 6) v[4:0] = 5'd0;
        else if (v[4:0] == 5'd0) v[2] = 1'b1;
        plan.push_back(v);
      end
      ref_run(addr, cnt, bm, 1'b0);
      do_req(addr, 16'(cnt), bm, (n == 0) ? 1 : 0);
      check_req("rnd");
    end

    // Asynchronous reset while the arm strobe is high
    no_run = 1'b1;
    @(negedge clk);
    i_blk_addr = 32'h10; i_blk_cnt = 16'd5; i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    #2;
    chk("midrst.armed", o_start_reading, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.start_reading", o_start_reading, 0);
    chk("midrst.busy", o_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_run = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
